// File: rtl/control_estacionamiento.sv
// Single-lane parking gate controller: shared entry/exit barrier,
// occupancy counter, round-robin arbitration and per-barrier timeout.
module control_estacionamiento #(
    parameter int CAPACIDAD = 7,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_in,
    input  logic       sensor_out,
    input  logic       paso_in,
    input  logic       paso_out,
    output logic       barrera_in,
    output logic       barrera_out,
    output logic [2:0] autos,
    output logic       lleno,
    output logic       vacio,
    output logic       timeout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ABRE_IN  = 2'd1;
    localparam logic [1:0] ABRE_OUT = 2'd2;
    localparam logic [1:0] CIERRE   = 2'd3;

    localparam logic       ULT_OUT = 1'b0;
    localparam logic       ULT_IN  = 1'b1;

    localparam logic [2:0] CAP  = 3'(CAPACIDAD);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] autos_q, autos_d;
    logic       ultimo_q, ultimo_d;
    logic       timeout_q, timeout_d;
    logic       req_in, req_out;

    assign lleno   = (autos_q == CAP);
    assign vacio   = (autos_q == 3'd0);
    assign req_in  = sensor_in && !lleno;
    assign req_out = sensor_out && !vacio;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        autos_d   = autos_q;
        ultimo_d  = ultimo_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Entry wins a tie only if exit was served last
                if (req_in && (!req_out || ultimo_q == ULT_OUT)) begin
                    state_d = ABRE_IN;
                    timer_d = 8'd0;
                end else if (req_out) begin
                    state_d = ABRE_OUT;
                    timer_d = 8'd0;
                end
            end
            ABRE_IN: begin
                if (paso_in) begin
                    if (autos_q != CAP) autos_d = autos_q + 3'd1;
                    ultimo_d = ULT_IN;
                    state_d  = CIERRE;
                end else if (timer_q == TMAX) begin
                    timeout_d = 1'b1;
                    ultimo_d  = ULT_IN;
                    state_d   = CIERRE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ABRE_OUT: begin
                if (paso_out) begin
                    if (autos_q != 3'd0) autos_d = autos_q - 3'd1;
                    ultimo_d = ULT_OUT;
                    state_d  = CIERRE;
                end else if (timer_q == TMAX) begin
                    timeout_d = 1'b1;
                    ultimo_d  = ULT_OUT;
                    state_d   = CIERRE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            CIERRE: begin
                state_d = IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 8'd0;
            autos_q   <= 3'd0;
            ultimo_q  <= ULT_OUT;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            autos_q   <= autos_d;
            ultimo_q  <= ultimo_d;
            timeout_q <= timeout_d;
        end
    end

    assign barrera_in  = (state_q == ABRE_IN);
    assign barrera_out = (state_q == ABRE_OUT);
    assign autos       = autos_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_control_estacionamiento.sv
// Bench for control_estacionamiento: directed table, corner sequences
// and random traffic against a lane-occupancy reference model.
module tb_control_estacionamiento;

    localparam int CAP = 7;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor_in = 1'b0;
    logic       sensor_out = 1'b0;
    logic       paso_in = 1'b0;
    logic       paso_out = 1'b0;
    logic       barrera_in;
    logic       barrera_out;
    logic [2:0] autos;
    logic       lleno;
    logic       vacio;
    logic       timeout;

    int checks = 0;
    int passed = 0;

    control_estacionamiento #(.CAPACIDAD(CAP), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .sensor_in(sensor_in),
        .sensor_out(sensor_out),
        .paso_in(paso_in),
        .paso_out(paso_out),
        .barrera_in(barrera_in),
        .barrera_out(barrera_out),
        .autos(autos),
        .lleno(lleno),
        .vacio(vacio),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference: lane side open (0 none, 1 entry, 2 exit), how many
    // cycles it has been open, and whether the lane is clearing.
    int m_count = 0;
    int m_side = 0;
    int m_opened = 0;
    bit m_closing = 1'b0;
    bit m_last_in = 1'b0;
    bit m_tout = 1'b0;

    task automatic model_step();
        bit want_in, want_out;
        if (rst) begin
            m_count = 0; m_side = 0; m_opened = 0;
            m_closing = 0; m_last_in = 0; m_tout = 0;
            return;
        end
        m_tout = 0;
        if (m_closing) begin
            m_closing = 0;
        end else if (m_side != 0) begin
            bit passed_car;
            passed_car = (m_side == 1) ? paso_in : paso_out;
            if (passed_car || m_opened == TO) begin
                if (passed_car && m_side == 1 && m_count < CAP) m_count++;
                if (passed_car && m_side == 2 && m_count > 0) m_count--;
                m_tout = !passed_car;
                m_last_in = (m_side == 1);
                m_side = 0;
                m_closing = 1;
            end else begin
                m_opened++;
            end
        end else begin
            want_in = sensor_in && (m_count < CAP);
            want_out = sensor_out && (m_count > 0);
            if (want_in && want_out) m_side = m_last_in ? 2 : 1;
            else if (want_in) m_side = 1;
            else if (want_out) m_side = 2;
            m_opened = 1;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_model();
        int act, exp;
        act = {barrera_in, barrera_out, autos, lleno, vacio, timeout};
        exp = {m_side == 1, m_side == 2, 3'(m_count),
               m_count == CAP, m_count == 0, m_tout};
        check("model_outputs", act, exp);
        if (barrera_in && barrera_out) check("exclusive", 1, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic clear_inputs();
        rst = 0; sensor_in = 0; sensor_out = 0; paso_in = 0; paso_out = 0;
    endtask

    typedef struct {
        bit       r, si, so, pi, po;
        bit       e_bin, e_bout;
        bit [2:0] e_autos;
        bit       e_tout;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int hi, tp, w, bin_seen;
        bit side_in;

        tbl[0]  = '{1,0,0,0,0, 0,0,3'd0,0};
        tbl[1]  = '{0,1,0,0,0, 1,0,3'd0,0};
        tbl[2]  = '{0,0,0,0,0, 1,0,3'd0,0};
        tbl[3]  = '{0,0,0,0,0, 1,0,3'd0,0};
        tbl[4]  = '{0,0,0,1,0, 0,0,3'd1,0};
        tbl[5]  = '{0,0,0,0,0, 0,0,3'd1,0};
        tbl[6]  = '{0,0,1,0,0, 0,1,3'd1,0};
        tbl[7]  = '{0,0,0,0,1, 0,0,3'd0,0};
        tbl[8]  = '{0,0,0,1,0, 0,0,3'd0,0};
        tbl[9]  = '{0,0,0,0,1, 0,0,3'd0,0};
        tbl[10] = '{0,0,1,0,0, 0,0,3'd0,0};
        tbl[11] = '{0,1,0,0,0, 1,0,3'd0,0};
        tbl[12] = '{1,0,0,0,0, 0,0,3'd0,0};
        tbl[13] = '{0,0,0,1,0, 0,0,3'd0,0};

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].r; sensor_in = tbl[i].si; sensor_out = tbl[i].so;
            paso_in = tbl[i].pi; paso_out = tbl[i].po;
            cycle();
            check($sformatf("tbl%0d_bin", i), barrera_in, tbl[i].e_bin);
            check($sformatf("tbl%0d_bout", i), barrera_out, tbl[i].e_bout);
            check($sformatf("tbl%0d_autos", i), autos, tbl[i].e_autos);
            check($sformatf("tbl%0d_tout", i), timeout, tbl[i].e_tout);
        end
        clear_inputs();
        cycle();
        check("vacio_after_tbl", vacio, 1);

        // Fill the lot
        for (int k = 0; k < CAP; k++) begin
            sensor_in = 1; cycle(); sensor_in = 0;
            paso_in = 1; cycle(); paso_in = 0;
            cycle();
        end
        check("full_autos", autos, CAP);
        check("full_lleno", lleno, 1);

        // Full lot ignores entry requests
        bin_seen = 0;
        sensor_in = 1;
        repeat (20) begin
            cycle();
            bin_seen += barrera_in;
        end
        sensor_in = 0;
        check("full_no_grant", bin_seen, 0);
        check("full_autos_hold", autos, CAP);

        // Exit barrier times out with no pass
        sensor_out = 1; cycle(); sensor_out = 0;
        hi = barrera_out; tp = 0;
        repeat (25) begin
            cycle();
            hi += barrera_out;
            tp += timeout;
        end
        check("timeout_open_cycles", hi, TO);
        check("timeout_pulses", tp, 1);
        check("timeout_autos", autos, CAP);

        // Drain down to 3 cars
        repeat (4) begin
            sensor_out = 1; cycle(); sensor_out = 0;
            paso_out = 1; cycle(); paso_out = 0;
            cycle();
        end
        check("drain_autos", autos, 3);

        // Both sides requesting: grants alternate starting with entry
        sensor_in = 1; sensor_out = 1;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            while (!barrera_in && !barrera_out && w < 6) begin
                cycle();
                w++;
            end
            if (!barrera_in && !barrera_out) begin
                check($sformatf("rr%0d_grant_wait", k), w, 0);
                break;
            end
            side_in = barrera_in;
            check($sformatf("rr%0d_side_in", k), side_in, (k % 2 == 0));
            if (side_in) paso_in = 1;
            else paso_out = 1;
            cycle();
            paso_in = 0; paso_out = 0;
            check($sformatf("rr%0d_autos", k), autos, (k % 2 == 0) ? 4 : 3);
        end
        clear_inputs();
        cycle();
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) == 0);
            sensor_in = $urandom_range(1);
            sensor_out = $urandom_range(1);
            paso_in = ($urandom_range(3) == 0);
            paso_out = ($urandom_range(3) == 0);
            cycle();
        end
        clear_inputs();
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/control_estacionamiento.md
CONTROL_ESTACIONAMIENTO -- requirements
Module: control_estacionamiento

Interface
REQ-001 Parameter CAPACIDAD, default 7: maximum cars admitted; legal range 1..7.
REQ-002 Parameter TIMEOUT, default 16: cycles a barrier stays open without a pass before auto-close; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 sensor_in  input  1  car waiting at entry barrier (level).
REQ-006 sensor_out  input  1  car waiting at exit barrier (level).
REQ-007 paso_in  input  1  car has passed the entry barrier (one-cycle pulse).
REQ-008 paso_out  input  1  car has passed the exit barrier (one-cycle pulse).
REQ-009 barrera_in  output  1  entry barrier open command (registered).
REQ-010 barrera_out  output  1  exit barrier open command (registered).
REQ-011 autos  output  3  current occupancy (registered).
REQ-012 lleno  output  1  high when autos == CAPACIDAD (combinational from autos).
REQ-013 vacio  output  1  high when autos == 0 (combinational from autos).
REQ-014 timeout  output  1  one-cycle pulse when a barrier closes without a pass.

Function
REQ-015 The block SHALL control a single shared lane: at most one of barrera_in/barrera_out high in any cycle.
REQ-016 FSM states SHALL be IDLE, ABRE_IN, ABRE_OUT, CIERRE; barrera_in high only in ABRE_IN, barrera_out high only in ABRE_OUT.
REQ-017 Entry request eligible = sensor_in && !lleno; exit request eligible = sensor_out && !vacio; ineligible requests SHALL be ignored.
REQ-018 IDLE: one eligible request -> grant it; both eligible -> grant the side not served last (round-robin flag ultimo); none -> stay IDLE.
REQ-019 Grant latency: request sampled in IDLE at edge N -> barrier high from edge N+1.
REQ-020 On entering ABRE_x the cycle timer SHALL clear to 0.
REQ-021 ABRE_IN: paso_in=1 -> autos+1, ultimo=entry, go CIERRE; else timer==TIMEOUT-1 -> timeout pulse, ultimo=entry, go CIERRE, autos unchanged; else timer+1.
REQ-022 ABRE_OUT: same as REQ-021 with paso_out, autos-1, ultimo=exit.
REQ-023 paso_in in any state other than ABRE_IN, and paso_out outside ABRE_OUT, SHALL be ignored (no count change).
REQ-024 paso and timeout in the same cycle: paso wins, no timeout pulse.
REQ-025 CIERRE SHALL last exactly one cycle with both barriers low, then IDLE; no grant is issued in CIERRE.
REQ-026 autos SHALL never exceed CAPACIDAD nor go below 0; no wrap-around under any input sequence.
REQ-027 timeout SHALL be high only in the cycle the FSM moves ABRE_x -> CIERRE via timer expiry.

Reset
REQ-028 rst high at a rising edge SHALL force state=IDLE, autos=0, timer=0, ultimo=exit (entry wins first tie), barrera_in=0, barrera_out=0, timeout=0; hence vacio=1, lleno=0.
REQ-029 rst asserted while a barrier is open SHALL close it on that edge with no count change; rst has priority over every other input.

Verification
REQ-030 After reset, sensor_in=1 one cycle; paso_in pulse 3 cycles after grant -> barrera_in high for 3 cycles, autos 0->1, CIERRE 1 cycle, IDLE.
REQ-031 autos=7 (CAPACIDAD=7), sensor_in=1 held 20 cycles -> barrera_in stays 0, autos stays 7, lleno=1; sensor_out=1 then served normally.
REQ-032 autos=3, sensor_in=sensor_out=1 held continuously, paso on each grant -> grants alternate entry, exit, entry...; barriers never high together; autos alternates 4,3,4.
REQ-033 sensor_out=1, no paso_out, TIMEOUT=16 -> barrera_out high exactly 16 cycles, timeout pulse 1 cycle, autos unchanged.
REQ-034 autos=0, sensor_out=1 and stray paso_in/paso_out pulses in IDLE -> no grant, autos stays 0, vacio=1.
REQ-035 barrera_in open, rst pulsed before paso_in -> next cycle barrera_in=0, autos=0, state IDLE; later paso_in ignored.
